// File: rtl/uart_ultrasword_jonz9.sv
// uart_ultrasword_jonz9
//   Tiny Tapeout user block: full-duplex UART with a fixed baud divider.
//   The default frame is 8N1. When UART_PARITY_EN is defined, the frame is
//   8E1: an even-parity bit follows D7, and a receive parity mismatch is
//   treated exactly like a bad stop bit.
//
// Parameter
//   CLKS_PER_BIT : clock cycles per UART bit (>= 4)
//
// Ports
//   clk     : system clock
//   rst_n   : asynchronous active-low reset
//   ena     : design-selected (ignored)
//   ui_in   : [0] rx line, [1] tx_start_n, [2] nib_sel, [3] rx_ack_n
//   uo_out  : [0] tx line, [1] tx_busy, [2] rx_valid, [3] rx_err,
//             [7:4] rx_data nibble selected by nib_sel
//   uio_in  : TX data byte, latched when a frame starts
//   uio_out : constant 0
//   uio_oe  : constant 0 (all uio pins are inputs)
//
// Strobes: tx_start_n and rx_ack_n act on their falling edge, seen after a
// 2-flop synchroniser. Registered outputs change on the 3rd rising clk after
// the pin falls. No valid/ready handshake exists here: a start strobe that
// arrives while tx_busy=1 is dropped, and rx_valid stays set until it is
// acknowledged (an unacknowledged frame is overwritten).
module uart_ultrasword_jonz9 #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  // State encodings are shared by the TX and RX FSMs.
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd4;
`ifdef UART_PARITY_EN
  localparam logic [2:0] S_PAR   = 3'd3;
`endif

  // ---------------------------------------------------------------------
  // Input synchronisers. Everything resets to 1 (the idle level), so a pin
  // held high through reset never produces an event.
  // ---------------------------------------------------------------------
  logic [1:0] rx_ff, st_ff, ack_ff;
  logic       st_prev, ack_prev;
  logic       rx_s, st_s, ack_s;
  logic       start_ev, ack_ev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_ff    <= 2'b11;
      st_ff    <= 2'b11;
      ack_ff   <= 2'b11;
      st_prev  <= 1'b1;
      ack_prev <= 1'b1;
    end else begin
      rx_ff    <= {rx_ff[0], ui_in[0]};
      st_ff    <= {st_ff[0], ui_in[1]};
      ack_ff   <= {ack_ff[0], ui_in[3]};
      st_prev  <= st_s;
      ack_prev <= ack_s;
    end
  end

  assign rx_s     = rx_ff[1];
  assign st_s     = st_ff[1];
  assign ack_s    = ack_ff[1];
  assign start_ev = !st_s && st_prev;
  assign ack_ev   = !ack_s && ack_prev;

  // ---------------------------------------------------------------------
  // Transmitter
  // ---------------------------------------------------------------------
  logic [2:0]    tx_state;
  logic [CW-1:0] tx_cnt;
  logic [2:0]    tx_bit;
  logic [7:0]    tx_shreg;
  logic          tx;
  logic          tx_busy;
`ifdef UART_PARITY_EN
  logic          tx_par;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state <= S_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shreg <= '0;
      tx       <= 1'b1;
`ifdef UART_PARITY_EN
      tx_par   <= 1'b0;
`endif
    end else begin
      case (tx_state)
        S_IDLE: begin
          tx     <= 1'b1;
          tx_cnt <= '0;
          if (start_ev) begin
            // Byte is captured here; later uio_in changes do not reach the line.
            tx_shreg <= uio_in;
`ifdef UART_PARITY_EN
            tx_par   <= ^uio_in;
`endif
            tx       <= 1'b0;
            tx_state <= S_START;
          end
        end
        S_START: begin
          if (tx_cnt == BIT_LAST) begin
            tx_cnt   <= '0;
            tx       <= tx_shreg[0];
            tx_shreg <= {1'b0, tx_shreg[7:1]};
            tx_bit   <= '0;
            tx_state <= S_DATA;
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (tx_cnt == BIT_LAST) begin
            tx_cnt <= '0;
            if (tx_bit == 3'd7) begin
`ifdef UART_PARITY_EN
              tx       <= tx_par;
              tx_state <= S_PAR;
`else
              tx       <= 1'b1;
              tx_state <= S_STOP;
`endif
            end else begin
              tx       <= tx_shreg[0];
              tx_shreg <= {1'b0, tx_shreg[7:1]};
              tx_bit   <= tx_bit + 1'b1;
            end
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
`ifdef UART_PARITY_EN
        S_PAR: begin
          if (tx_cnt == BIT_LAST) begin
            tx_cnt   <= '0;
            tx       <= 1'b1;
            tx_state <= S_STOP;
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
`endif
        S_STOP: begin
          if (tx_cnt == BIT_LAST) begin
            tx_cnt   <= '0;
            tx_state <= S_IDLE;
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        default: begin
          tx       <= 1'b1;
          tx_cnt   <= '0;
          tx_state <= S_IDLE;
        end
      endcase
    end
  end

  // Busy comes straight from the state register, so it drops on the edge
  // that returns the FSM to IDLE and clears asynchronously with reset.
  assign tx_busy = (tx_state != S_IDLE);

  // ---------------------------------------------------------------------
  // Receiver
  // ---------------------------------------------------------------------
  logic [2:0]    rx_state;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_bit;
  logic [7:0]    rx_shreg;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          rx_err;
  logic          rx_done;    // stop bit sampled; waiting for line high
  logic          par_bad;
`ifdef UART_PARITY_EN
  logic          rx_par_bad;
  assign par_bad = rx_par_bad;
`else
  assign par_bad = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state   <= S_IDLE;
      rx_cnt     <= '0;
      rx_bit     <= '0;
      rx_shreg   <= '0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      rx_err     <= 1'b0;
      rx_done    <= 1'b0;
`ifdef UART_PARITY_EN
      rx_par_bad <= 1'b0;
`endif
    end else begin
      // Ack is applied first so a frame completing on the same edge wins.
      if (ack_ev) begin
        rx_valid <= 1'b0;
        rx_err   <= 1'b0;
      end
      case (rx_state)
        S_IDLE: begin
          rx_cnt  <= '0;
          rx_done <= 1'b0;
          if (!rx_s) rx_state <= S_START;
        end
        S_START: begin
          // Re-check the start bit at mid-bit to reject short glitches.
          if (rx_cnt == HALF_LAST) begin
            rx_cnt <= '0;
            rx_bit <= '0;
            rx_state <= rx_s ? S_IDLE : S_DATA;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (rx_cnt == BIT_LAST) begin
            rx_cnt   <= '0;
            rx_shreg <= {rx_s, rx_shreg[7:1]};
            if (rx_bit == 3'd7) begin
`ifdef UART_PARITY_EN
              rx_state <= S_PAR;
`else
              rx_state <= S_STOP;
`endif
            end else begin
              rx_bit <= rx_bit + 1'b1;
            end
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
`ifdef UART_PARITY_EN
        S_PAR: begin
          if (rx_cnt == BIT_LAST) begin
            rx_cnt     <= '0;
            rx_par_bad <= (^rx_shreg) ^ rx_s;
            rx_state   <= S_STOP;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
`endif
        S_STOP: begin
          if (!rx_done) begin
            if (rx_cnt == BIT_LAST) begin
              rx_cnt  <= '0;
              rx_done <= 1'b1;
              if (rx_s && !par_bad) begin
                rx_data  <= rx_shreg;
                rx_valid <= 1'b1;
                rx_err   <= 1'b0;
              end else begin
                rx_err <= 1'b1;
              end
            end else begin
              rx_cnt <= rx_cnt + 1'b1;
            end
          end else if (rx_s) begin
            // A break (line held low) parks the receiver here.
            rx_done  <= 1'b0;
            rx_state <= S_IDLE;
          end
        end
        default: begin
          rx_cnt   <= '0;
          rx_done  <= 1'b0;
          rx_state <= S_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  logic [3:0] nibble;
  assign nibble  = ui_in[2] ? rx_data[7:4] : rx_data[3:0];
  assign uo_out  = {nibble, rx_err, rx_valid, tx_busy, tx};
  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;

  logic unused_ok;
  assign unused_ok = &{1'b0, ena, ui_in[7:4]};

endmodule

// File: tb/tb_uart_ultrasword_jonz9.sv
module tb_uart_ultrasword_jonz9;

  localparam int CPB = 16;
`ifdef UART_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out, uio_out, uio_oe;
  logic       loop_en = 1'b0;
  logic [7:0] dut_ui;

  always #5 clk = ~clk;

  // Loopback routes the DUT's own tx line onto its rx pin.
  assign dut_ui = {ui_in[7:1], loop_en ? uo_out[0] : ui_in[0]};

  uart_ultrasword_jonz9 #(.CLKS_PER_BIT(CPB)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (1'b1),
    .ui_in   (dut_ui),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic exp_tx_bit(input logic [7:0] d, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return d[k-1];
`ifdef UART_PARITY_EN
    if (k == 9) return ^d;
`endif
    return 1'b1;
  endfunction

  // Starts a TX frame of byte d and checks every bit at mid-bit plus the
  // exact busy length. With disturb set, a second start strobe and a new
  // uio_in value are applied mid-frame; neither may affect the frame.
  task automatic tx_frame(input logic [7:0] d, input logic disturb);
    uio_in = d;
    ui_in[1] = 1'b0;
    tick(2);
    check("tx_before_3rd_edge", {30'd0, uo_out[1:0]}, 32'h1);
    ui_in[1] = 1'b1;
    tick(1);
    check("tx_start_edge", {30'd0, uo_out[1:0]}, 32'h2);
    tick(CPB / 2);
    check("tx_bit0_start", {31'd0, uo_out[0]}, 32'h0);
    for (int k = 1; k < FRAME_BITS; k++) begin
      if (disturb && k == 3) begin
        ui_in[1] = 1'b0;
        uio_in = ~d;
        tick(2);
        ui_in[1] = 1'b1;
        tick(CPB - 2);
      end else begin
        tick(CPB);
      end
      check($sformatf("tx_%02h_bit%0d", d, k), {31'd0, uo_out[0]}, {31'd0, exp_tx_bit(d, k)});
    end
    tick(CPB / 2 - 1);
    check("tx_busy_last_cycle", {31'd0, uo_out[1]}, 32'h1);
    tick(1);
    check("tx_busy_dropped", {30'd0, uo_out[1:0]}, 32'h1);
  endtask

  function automatic logic [10:0] make_frame(input logic [7:0] d, input logic stop_bit);
`ifdef UART_PARITY_EN
    return {stop_bit, ^d, d, 1'b0};
`else
    return {1'b0, stop_bit, d, 1'b0};
`endif
  endfunction

  task automatic rx_drive(input logic [10:0] bits);
    for (int i = 0; i < FRAME_BITS; i++) begin
      ui_in[0] = bits[i];
      tick(CPB);
    end
    ui_in[0] = 1'b1;
    tick(4);
  endtask

  task automatic ack_pulse();
    ui_in[3] = 1'b0;
    tick(2);
    ui_in[3] = 1'b1;
    tick(2);
  endtask

  task automatic nib_check(input string tag, input logic sel, input logic [3:0] exp);
    ui_in[2] = sel;
    #1;
    check(tag, {28'd0, uo_out[7:4]}, {28'd0, exp});
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    int bad;
    logic [7:0] lb [3];
    lb[0] = 8'h00; lb[1] = 8'hFF; lb[2] = 8'h5A;

    // Reset with all inputs idle.
    rst_n = 1'b0;
    ui_in = 8'hFF;
    uio_in = 8'h00;
    tick(8);
    check("reset_uo_out", {24'd0, uo_out}, 32'h01);
    check("reset_uio_oe", {24'd0, uio_oe}, 32'h00);
    check("reset_uio_out", {24'd0, uio_out}, 32'h00);
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (uo_out !== 8'h01) bad++;
    end
    check("idle_after_reset", bad, 0);

    // TX of 0xA5, then a frame disturbed by a second start strobe.
    tx_frame(8'hA5, 1'b0);
    tick(5);
    tx_frame(8'h3C, 1'b1);
    tick(5);

    // RX of 0x3C, nibble readout, ack.
    rx_drive(make_frame(8'h3C, 1'b1));
    check("rx_3c_flags", {28'd0, uo_out[3:2], 2'b00}, 32'h4);
    nib_check("rx_3c_low_nib", 1'b0, 4'hC);
    nib_check("rx_3c_high_nib", 1'b1, 4'h3);
    ack_pulse();
    check("rx_ack_clears", {30'd0, uo_out[3:2]}, 32'h0);
    nib_check("rx_data_kept_after_ack", 1'b0, 4'hC);

    // Bad stop bit: error only, data unchanged.
    rx_drive(make_frame(8'h81, 1'b0));
    check("rx_bad_stop_flags", {30'd0, uo_out[3:2]}, 32'h2);
    nib_check("rx_bad_stop_data_low", 1'b0, 4'hC);
    nib_check("rx_bad_stop_data_high", 1'b1, 4'h3);
    ack_pulse();
    check("rx_ack_clears_err", {30'd0, uo_out[3:2]}, 32'h0);

    // Quarter-bit glitch is rejected.
    ui_in[0] = 1'b0;
    tick(CPB / 4);
    ui_in[0] = 1'b1;
    tick(2 * CPB);
    check("rx_glitch_no_flags", {30'd0, uo_out[3:2]}, 32'h0);
    nib_check("rx_glitch_data_kept", 1'b0, 4'hC);

    // Overrun: second good frame overwrites data, valid stays set.
    rx_drive(make_frame(8'h11, 1'b1));
    check("rx_11_valid", {30'd0, uo_out[3:2]}, 32'h1);
    rx_drive(make_frame(8'h7E, 1'b1));
    check("rx_overrun_valid", {30'd0, uo_out[3:2]}, 32'h1);
    nib_check("rx_overrun_low", 1'b0, 4'hE);
    nib_check("rx_overrun_high", 1'b1, 4'h7);
    ack_pulse();

`ifdef UART_PARITY_EN
    // Corrupted parity bit: error, no valid, no data update.
    rx_drive(make_frame(8'h5A, 1'b1) ^ 11'h200);
    check("rx_parity_err_flags", {30'd0, uo_out[3:2]}, 32'h2);
    nib_check("rx_parity_err_data", 1'b0, 4'hE);
    ack_pulse();
`endif

    // Asynchronous reset in the middle of a TX frame of 0x00.
    uio_in = 8'h00;
    ui_in[1] = 1'b0;
    tick(2);
    ui_in[1] = 1'b1;
    tick(1 + 3 * CPB);
    check("tx_midframe_low", {30'd0, uo_out[1:0]}, 32'h2);
    #4;
    rst_n = 1'b0;
    #1;
    check("async_reset_tx", {30'd0, uo_out[1:0]}, 32'h1);
    tick(2);
    rst_n = 1'b1;
    tick(2);
    check("after_reset_uo_out", {24'd0, uo_out}, 32'h01);

    // Loopback.
    loop_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      uio_in = lb[i];
      ui_in[1] = 1'b0;
      tick(2);
      ui_in[1] = 1'b1;
      tick(FRAME_BITS * CPB + 10);
      check($sformatf("loop_%02h_flags", lb[i]), {30'd0, uo_out[3:2]}, 32'h1);
      nib_check($sformatf("loop_%02h_low", lb[i]), 1'b0, lb[i][3:0]);
      nib_check($sformatf("loop_%02h_high", lb[i]), 1'b1, lb[i][7:4]);
      ack_pulse();
    end
    loop_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
